// File: rtl/irq_ctrl_avalon.sv
// irq_ctrl_avalon: Avalon-MM interrupt controller with per-source capture.
// Optional macro IRQ_CTRL_SYNC_EN adds the first synchronizer stage.
module irq_ctrl_avalon #(
    parameter int n_irq = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       address,
    output logic [31:0]      readdata,
    input  logic [31:0]      writedata,
    input  logic             write,
    input  logic             chipselect,
    input  logic [n_irq-1:0] irq_in,
    output logic             irq_out
);

    localparam logic [2:0] A_PEND   = 3'd0;
    localparam logic [2:0] A_ENABLE = 3'd1;
    localparam logic [2:0] A_MODE   = 3'd2;
    localparam logic [2:0] A_ACTIVE = 3'd3;
    localparam logic [2:0] A_ID     = 3'd4;

    logic [n_irq-1:0] s2_q;
    logic [n_irq-1:0] s2d_q;
    logic [n_irq-1:0] pend_q,   pend_d;
    logic [n_irq-1:0] enable_q, enable_d;
    logic [n_irq-1:0] mode_q,   mode_d;
    logic [31:0]      rdata_q,  rdata_d;
    logic             irq_q,    irq_d;

    logic             wr;
    logic [n_irq-1:0] wdata;
    logic [n_irq-1:0] clr;
    logic [n_irq-1:0] mode_chg;
    logic [n_irq-1:0] rise;
    logic [n_irq-1:0] active;
    logic [4:0]       id_idx;
    logic [31:0]      id_word;

    // upper write-data bits have no register behind them
    logic unused_wd;
    assign unused_wd = ^writedata;

    function automatic logic [31:0] zext(input logic [n_irq-1:0] v);
        logic [31:0] r;
        r = '0;
        r[n_irq-1:0] = v;
        return r;
    endfunction

`ifdef IRQ_CTRL_SYNC_EN
    logic [n_irq-1:0] s1_q;

    // two-flop synchronizer plus edge-detect history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s2d_q <= '0;
        end else begin
            s1_q  <= irq_in;
            s2_q  <= s1_q;
            s2d_q <= s2_q;
        end
    end
`else
    // same-domain sources: single sampling stage plus history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_q  <= '0;
            s2d_q <= '0;
        end else begin
            s2_q  <= irq_in;
            s2d_q <= s2_q;
        end
    end
`endif

    assign wr     = chipselect & write;
    assign wdata  = writedata[n_irq-1:0];
    assign rise   = s2_q & ~s2d_q;
    assign active = pend_q & enable_q;

    // decode write strobes into clear and mode-change masks
    always_comb begin
        clr      = '0;
        mode_chg = '0;
        if (wr && address == A_PEND) begin
            clr = wdata;
        end
        if (wr && address == A_MODE) begin
            mode_chg = wdata ^ mode_q;
        end
    end

    // per-source pending update; a mode change drops the old state
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < n_irq; i++) begin
            if (mode_chg[i]) begin
                pend_d[i] = 1'b0;
            end else if (mode_q[i]) begin
                pend_d[i] = (pend_q[i] & ~clr[i]) | rise[i];
            end else begin
                pend_d[i] = s2_q[i];
            end
        end
    end

    // control register next state
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr && address == A_ENABLE) begin
            enable_d = wdata;
        end
        if (wr && address == A_MODE) begin
            mode_d = wdata;
        end
    end

    // lowest-index active source wins
    always_comb begin
        id_idx = '0;
        for (int i = n_irq - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_idx = 5'(i);
            end
        end
        id_word = '0;
        if (|active) begin
            id_word = {1'b1, 26'b0, id_idx};
        end
    end

    // read mux, registered every cycle without side effects
    always_comb begin
        rdata_d = '0;
        case (address)
            A_PEND:   rdata_d = zext(pend_q);
            A_ENABLE: rdata_d = zext(enable_q);
            A_MODE:   rdata_d = zext(mode_q);
            A_ACTIVE: rdata_d = zext(active);
            A_ID:     rdata_d = id_word;
            default:  rdata_d = '0;
        endcase
        irq_d = |active;
    end

    // architectural state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q   <= '0;
            enable_q <= '0;
            mode_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq_out  = irq_q;

endmodule

// File: tb/tb_irq_ctrl_avalon.sv
// tb_irq_ctrl_avalon: directed bench for irq_ctrl_avalon.
// Read results flow through an expected-value queue.
module tb_irq_ctrl_avalon;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] readdata;
    logic [31:0] writedata = '0;
    logic        write = 1'b0;
    logic        chipselect = 1'b0;
    logic [7:0]  irq_in = '0;
    logic        irq_out;

    int checks = 0;
    int passed = 0;
    int fails = 0;

    logic [31:0] expq[$];
    string       tagq[$];

    irq_ctrl_avalon #(.n_irq(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .address    (address),
        .readdata   (readdata),
        .writedata  (writedata),
        .write      (write),
        .chipselect (chipselect),
        .irq_in     (irq_in),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        write      = 1'b1;
        chipselect = 1'b1;
        tick();
        write      = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [31:0] exp);
        logic [31:0] e;
        string t;
        address    = a;
        chipselect = 1'b1;
        expq.push_back(exp);
        tagq.push_back(tag);
        tick();
        chipselect = 1'b0;
        e = expq.pop_front();
        t = tagq.pop_front();
        chk(t, readdata, e);
    endtask

    initial begin
        irq_in = 8'hFF;
        repeat (3) tick();
        chk("rst_irq", {31'b0, irq_out}, 32'h0);
        chk("rst_rdata", readdata, 32'h0);
        irq_in = 8'h00;
        rstn   = 1'b1;
        tick();
        rd("rst_pend", 3'd0, 32'h0);
        rd("rst_en", 3'd1, 32'h0);
        rd("rst_mode", 3'd2, 32'h0);
        rd("rst_act", 3'd3, 32'h0);
        rd("rst_id", 3'd4, 32'h0);
        chk("rst_irq2", {31'b0, irq_out}, 32'h0);

        // level mode on source 3
        wr(3'd1, 32'h08);
        irq_in = 8'h08;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("lvl_rise%0d", i), {31'b0, irq_out},
                {31'b0, i >= L + 1});
        end
        rd("lvl_id", 3'd4, 32'h8000_0003);
        rd("lvl_pend", 3'd0, 32'h08);
        tick();
        tick();
        irq_in = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("lvl_fall%0d", i), {31'b0, irq_out},
                {31'b0, i < L + 1});
        end
        rd("lvl_pend0", 3'd0, 32'h0);

        // edge capture and W1C on source 0
        wr(3'd2, 32'h01);
        wr(3'd1, 32'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        repeat (L + 2) tick();
        rd("edge_pend", 3'd0, 32'h01);
        repeat (4) tick();
        rd("edge_sticky", 3'd0, 32'h01);
        chk("edge_irq", {31'b0, irq_out}, 32'h1);
        wr(3'd0, 32'h01);
        chk("w1c_irq_k", {31'b0, irq_out}, 32'h1);
        tick();
        chk("w1c_irq_k1", {31'b0, irq_out}, 32'h0);
        rd("w1c_pend", 3'd0, 32'h0);

        // clear coinciding with a detected edge
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        repeat (L - 2) tick();
        wr(3'd0, 32'h01);
        rd("set_wins", 3'd0, 32'h01);
        wr(3'd0, 32'h01);
        rd("set_clr", 3'd0, 32'h0);

        // priority and masking, all level mode
        wr(3'd2, 32'h00);
        wr(3'd1, 32'h20);
        irq_in = 8'h24;
        repeat (L + 2) tick();
        rd("pri_id5", 3'd4, 32'h8000_0005);
        rd("pri_act", 3'd3, 32'h20);
        chk("pri_irq", {31'b0, irq_out}, 32'h1);
        wr(3'd1, 32'hFF);
        rd("pri_id2", 3'd4, 32'h8000_0002);
        rd("pri_act2", 3'd3, 32'h24);
        wr(3'd1, 32'h00);
        tick();
        rd("mask_id", 3'd4, 32'h0);
        chk("mask_irq", {31'b0, irq_out}, 32'h0);
        rd("mask_pend", 3'd0, 32'h24);

        // mode switch drops a latched edge
        irq_in = 8'h00;
        repeat (L + 1) tick();
        wr(3'd2, 32'h02);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        repeat (L + 1) tick();
        rd("ms_pend", 3'd0, 32'h02);
        wr(3'd2, 32'h00);
        rd("ms_clr", 3'd0, 32'h0);
        repeat (3) tick();
        rd("ms_stay", 3'd0, 32'h0);
        rd("ms_mode", 3'd2, 32'h0);

        // unused addresses and chipselect gating
        rd("a14", 3'd5, 32'h0);
        wr(3'd6, 32'hFFFF_FFFF);
        rd("a18", 3'd6, 32'h0);
        rd("a18_en", 3'd1, 32'h0);
        address    = 3'd1;
        writedata  = 32'h0F;
        write      = 1'b1;
        chipselect = 1'b0;
        tick();
        write = 1'b0;
        rd("no_cs", 3'd1, 32'h0);

        // async reset with an edge inside the synchronizer
        wr(3'd2, 32'h01);
        wr(3'd1, 32'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        rstn = 1'b0;
        #1;
        chk("arst_irq", {31'b0, irq_out}, 32'h0);
        chk("arst_rdata", readdata, 32'h0);
        tick();
        rstn = 1'b1;
        repeat (L + 2) tick();
        rd("arst_pend", 3'd0, 32'h0);
        rd("arst_mode", 3'd2, 32'h0);
        chk("arst_irq2", {31'b0, irq_out}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
